// File: rtl/alu_writeback_psr_if.sv
// Bus between the ALU, this writeback stage and the register-file write port.
// Handshakes: in_valid/in_ready transfer when both are 1 on a rising edge; rf_we/rf_ready likewise.
interface alu_writeback_psr_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] alu_result;
  logic              alu_carry;
  logic              alu_flag;
  logic              alu_low;
  logic              alu_negative;
  logic              alu_zero;
  logic [4:0]        psr_mask;
  logic              wb_en;
  logic [ADDR_W-1:0] wb_addr;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              rf_ready;

  modport master (
    output in_valid, alu_result, alu_carry, alu_flag, alu_low, alu_negative, alu_zero,
    output psr_mask, wb_en, wb_addr, rf_ready,
    input  in_ready, rf_we, rf_waddr, rf_wdata
  );

  modport slave (
    input  in_valid, alu_result, alu_carry, alu_flag, alu_low, alu_negative, alu_zero,
    input  psr_mask, wb_en, wb_addr, rf_ready,
    output in_ready, rf_we, rf_waddr, rf_wdata
  );
endinterface

// File: rtl/alu_writeback_psr.sv
// ALU writeback stage: holds the PSR, feeds Carry back to the ALU and queues
// register-file writes in an in-order FIFO with a youngest-match forwarding lookup.
module alu_writeback_psr #(
   parameter int DEPTH  = 2,
   parameter int DATA_W = 16,
   parameter int ADDR_W = 4
) (
   input  logic                clk,
   input  logic                reset_n,
   alu_writeback_psr_if.slave  bus,
   output logic [4:0]          psr,
   output logic                carry_to_alu,
   input  logic [ADDR_W-1:0]   fwd_addr,
   output logic                fwd_hit,
   output logic [DATA_W-1:0]   fwd_data,
   input  logic                psr_clear
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [ADDR_W-1:0] addr_q [DEPTH];
   logic [DATA_W-1:0] data_q [DEPTH];
   logic [PTR_W-1:0]  head;
   logic [PTR_W-1:0]  tail;
   logic [CNT_W-1:0]  count;
   logic              accept;
   logic              enq;
   logic              deq;
   logic [4:0]        flags;

   // in_ready looks only at the registered count so it never depends on rf_ready.
   assign bus.in_ready = (count < CNT_W'(DEPTH));
   assign accept       = bus.in_valid && bus.in_ready;
   assign enq          = accept && bus.wb_en;
   assign deq          = bus.rf_we && bus.rf_ready;
   assign flags        = {bus.alu_carry, bus.alu_flag, bus.alu_low, bus.alu_negative, bus.alu_zero};

   assign bus.rf_we    = (count != '0);
   assign bus.rf_waddr = addr_q[head];
   assign bus.rf_wdata = data_q[head];
   assign carry_to_alu = psr[4];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         psr <= '0;
      end else if (psr_clear) begin
         psr <= '0;
      end else if (accept) begin
         psr <= (psr & ~bus.psr_mask) | (flags & bus.psr_mask);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            addr_q[i] <= '0;
            data_q[i] <= '0;
         end
      end else begin
         if (enq) begin
            addr_q[tail] <= bus.wb_addr;
            data_q[tail] <= bus.alu_result;
            tail         <= tail + PTR_W'(1);
         end
         if (deq) begin
            head <= head + PTR_W'(1);
         end
         case ({enq, deq})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Walk oldest to youngest so the last match left standing is the youngest.
   always_comb begin
      logic [PTR_W-1:0] idx;
      fwd_hit  = 1'b0;
      fwd_data = '0;
      idx      = head;
      for (int i = 0; i < DEPTH; i++) begin
         idx = head + PTR_W'(i);
         if ((CNT_W'(i) < count) && (addr_q[idx] == fwd_addr)) begin
            fwd_hit  = 1'b1;
            fwd_data = data_q[idx];
         end
      end
   end
endmodule

// File: tb/tb_alu_writeback_psr.sv
// Self-checking bench for alu_writeback_psr: queue-based reference model compared
// every cycle, plus hand-computed directed expectations.
module tb_alu_writeback_psr;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 2;

  logic              clk;
  logic              reset_n;
  logic [4:0]        psr;
  logic              carry_to_alu;
  logic [ADDR_W-1:0] fwd_addr;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;
  logic              psr_clear;

  alu_writeback_psr_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  alu_writeback_psr #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .bus          (bus),
    .psr          (psr),
    .carry_to_alu (carry_to_alu),
    .fwd_addr     (fwd_addr),
    .fwd_hit      (fwd_hit),
    .fwd_data     (fwd_data),
    .psr_clear    (psr_clear)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  // model state: PSR and pending writes as {addr, data}, oldest first
  logic [4:0]               psr_m;
  logic [ADDR_W+DATA_W-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      psr_m = 5'b0;
      exp_q.delete();
    end else begin
      bit acc;
      bit drained;
      acc     = bus.in_valid && (exp_q.size() < DEPTH);
      drained = (exp_q.size() != 0) && bus.rf_ready;
      if (psr_clear) begin
        psr_m = 5'b0;
      end else if (acc) begin
        logic [4:0] f;
        f = {bus.alu_carry, bus.alu_flag, bus.alu_low, bus.alu_negative, bus.alu_zero};
        for (int b = 0; b < 5; b++)
          if (bus.psr_mask[b]) psr_m[b] = f[b];
      end
      if (drained) void'(exp_q.pop_front());
      if (acc && bus.wb_en) exp_q.push_back({bus.wb_addr, bus.alu_result});
    end
  end

  // compare process, away from the active edge
  always @(negedge clk) begin
    if (chk_en && reset_n) begin
      bit                hit_m;
      logic [DATA_W-1:0] dat_m;
      hit_m = 1'b0;
      dat_m = '0;
      for (int k = 0; k < exp_q.size(); k++) begin
        if (exp_q[k][ADDR_W+DATA_W-1:DATA_W] == fwd_addr) begin
          hit_m = 1'b1;
          dat_m = exp_q[k][DATA_W-1:0];
        end
      end
      chk("psr", 32'(psr), 32'(psr_m));
      chk("carry_to_alu", 32'(carry_to_alu), 32'(psr_m[4]));
      chk("in_ready", 32'(bus.in_ready), 32'(exp_q.size() < DEPTH));
      chk("rf_we", 32'(bus.rf_we), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        chk("rf_waddr", 32'(bus.rf_waddr), 32'(exp_q[0][ADDR_W+DATA_W-1:DATA_W]));
        chk("rf_wdata", 32'(bus.rf_wdata), 32'(exp_q[0][DATA_W-1:0]));
      end
      chk("fwd_hit", 32'(fwd_hit), 32'(hit_m));
      if (hit_m) chk("fwd_data", 32'(fwd_data), 32'(dat_m));
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_in(input bit v, input logic [DATA_W-1:0] d, input logic [4:0] f,
                        input logic [4:0] m, input bit wb, input logic [ADDR_W-1:0] a);
    bus.in_valid     = v;
    bus.alu_result   = d;
    {bus.alu_carry, bus.alu_flag, bus.alu_low, bus.alu_negative, bus.alu_zero} = f;
    bus.psr_mask     = m;
    bus.wb_en        = wb;
    bus.wb_addr      = a;
  endtask

  task automatic idle();
    set_in(1'b0, '0, 5'b0, 5'b0, 1'b0, '0);
  endtask

  initial begin
    reset_n      = 1'b0;
    psr_clear    = 1'b0;
    fwd_addr     = '0;
    bus.rf_ready = 1'b0;
    idle();
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    chk_en = 1'b1;
    #1;
    chk("reset_psr", 32'(psr), 32'h00);
    chk("reset_rf_we", 32'(bus.rf_we), 32'h0);
    chk("reset_in_ready", 32'(bus.in_ready), 32'h1);
    chk("reset_fwd_hit", 32'(fwd_hit), 32'h0);

    // accept 0x0000 with C=1,Z=1, full mask, write r3
    set_in(1'b1, 16'h0000, 5'b10001, 5'b11111, 1'b1, 4'd3);
    tick();
    idle();
    #1;
    chk("acc_psr", 32'(psr), 32'h11);
    chk("acc_carry", 32'(carry_to_alu), 32'h1);
    chk("acc_rf_we", 32'(bus.rf_we), 32'h1);
    chk("acc_rf_waddr", 32'(bus.rf_waddr), 32'h3);
    chk("acc_rf_wdata", 32'(bus.rf_wdata), 32'h0000);
    bus.rf_ready = 1'b1;
    tick();
    bus.rf_ready = 1'b0;

    // fill with two writes to r5, youngest must forward
    set_in(1'b1, 16'h1111, 5'b0, 5'b0, 1'b1, 4'd5);
    tick();
    set_in(1'b1, 16'h2222, 5'b0, 5'b0, 1'b1, 4'd5);
    tick();
    fwd_addr = 4'd5;
    set_in(1'b1, 16'h3333, 5'b01010, 5'b11111, 1'b1, 4'd7);
    #1;
    chk("full_in_ready", 32'(bus.in_ready), 32'h0);
    chk("full_fwd_hit", 32'(fwd_hit), 32'h1);
    chk("full_fwd_data", 32'(fwd_data), 32'h2222);
    tick();
    #1;
    chk("ignored_psr", 32'(psr), 32'h11);
    chk("ignored_in_ready", 32'(bus.in_ready), 32'h0);
    chk("ignored_rf_wdata", 32'(bus.rf_wdata), 32'h1111);

    // drain while full and in_valid held: accept lands one cycle later
    bus.rf_ready = 1'b1;
    tick();
    bus.rf_ready = 1'b0;
    #1;
    chk("drain_in_ready", 32'(bus.in_ready), 32'h1);
    chk("drain_rf_we", 32'(bus.rf_we), 32'h1);
    chk("drain_rf_wdata", 32'(bus.rf_wdata), 32'h2222);
    chk("drain_psr", 32'(psr), 32'h11);
    tick();
    idle();
    fwd_addr = 4'd7;
    #1;
    chk("reacc_in_ready", 32'(bus.in_ready), 32'h0);
    chk("reacc_psr", 32'(psr), 32'h0A);
    chk("reacc_fwd_data", 32'(fwd_data), 32'h3333);
    bus.rf_ready = 1'b1;
    repeat (2) tick();
    bus.rf_ready = 1'b0;

    // restore Carry=1, then a CMP-style accept that leaves Carry alone
    set_in(1'b1, 16'h0000, 5'b10000, 5'b10000, 1'b0, 4'd0);
    tick();
    set_in(1'b1, 16'h1234, 5'b00110, 5'b01111, 1'b0, 4'd1);
    tick();
    idle();
    #1;
    chk("cmp_psr", 32'(psr), 32'h16);
    chk("cmp_carry", 32'(carry_to_alu), 32'h1);
    chk("cmp_rf_we", 32'(bus.rf_we), 32'h0);

    // clear wins over the PSR update but the entry is still queued
    psr_clear = 1'b1;
    set_in(1'b1, 16'hBEEF, 5'b11111, 5'b11111, 1'b1, 4'd9);
    tick();
    psr_clear = 1'b0;
    idle();
    #1;
    chk("clr_psr", 32'(psr), 32'h00);
    chk("clr_rf_we", 32'(bus.rf_we), 32'h1);
    chk("clr_rf_waddr", 32'(bus.rf_waddr), 32'h9);
    chk("clr_rf_wdata", 32'(bus.rf_wdata), 32'hBEEF);
    bus.rf_ready = 1'b1;
    tick();
    bus.rf_ready = 1'b0;

    // reset while draining a full buffer
    set_in(1'b1, 16'h00A1, 5'b11111, 5'b11111, 1'b1, 4'd1);
    tick();
    set_in(1'b1, 16'h00A2, 5'b0, 5'b0, 1'b1, 4'd2);
    tick();
    idle();
    bus.rf_ready = 1'b1;
    fwd_addr     = 4'd1;
    reset_n      = 1'b0;
    #1;
    chk("mid_rst_rf_we", 32'(bus.rf_we), 32'h0);
    chk("mid_rst_in_ready", 32'(bus.in_ready), 32'h1);
    chk("mid_rst_psr", 32'(psr), 32'h00);
    chk("mid_rst_fwd_hit", 32'(fwd_hit), 32'h0);
    tick();
    reset_n = 1'b1;
    tick();
    #1;
    chk("post_rst_rf_we", 32'(bus.rf_we), 32'h0);
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'h1);
    bus.rf_ready = 1'b0;

    // mixed traffic exercising wrap, simultaneous enq/deq and forwarding
    for (int n = 0; n < 80; n++) begin
      set_in(1'($urandom_range(0, 1)), 16'($urandom_range(0, 16'hFFFF)),
             5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
             1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 3)));
      bus.rf_ready = 1'($urandom_range(0, 1));
      psr_clear    = ($urandom_range(0, 15) == 0);
      fwd_addr     = 4'($urandom_range(0, 3));
      tick();
    end
    idle();
    psr_clear    = 1'b0;
    bus.rf_ready = 1'b1;
    repeat (3) tick();
    #1;
    chk("final_rf_we", 32'(bus.rf_we), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
